// File: rtl/clock_cycle_sequencer.sv
// rtl/clock_cycle_sequencer.sv - closes the loop around a free-running counter and sequences LOAD/INTERROGATE/DETECT phases
module clock_cycle_sequencer #(
    parameter int Nbits             = 27,
    parameter int nclks_total       = 96830000,
    parameter int nclks_load        = 48415000,
    parameter int nclks_interrogate = 29049000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             abort,
    input  logic [Nbits-1:0] count_in,
    output logic             counter_reset,
    output logic             phase_load,
    output logic             phase_interrogate,
    output logic             phase_detect,
    output logic             cycle_done,
    output logic [15:0]      cycle_count,
    output logic             busy,
    output logic             err_overrun
);

    if (nclks_load < 1 || nclks_interrogate < 1 ||
        nclks_load + nclks_interrogate > nclks_total - 2 ||
        64'(nclks_total) > (64'd1 << Nbits)) begin : g_bad_params
        $error("clock_cycle_sequencer: inconsistent phase lengths or counter width");
    end

    // Phase boundaries as counter values; count_in is only ever compared, never computed on.
    localparam logic [Nbits-1:0] LOAD_END  = Nbits'(nclks_load - 1);
    localparam logic [Nbits-1:0] INT_START = Nbits'(nclks_load);
    localparam logic [Nbits-1:0] INT_END   = Nbits'(nclks_load + nclks_interrogate - 1);
    localparam logic [Nbits-1:0] DET_START = Nbits'(nclks_load + nclks_interrogate);
    localparam logic [Nbits-1:0] TOT_M2    = Nbits'(nclks_total - 2);
    localparam logic [Nbits-1:0] TOT_M1    = Nbits'(nclks_total - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_LOAD        = 2'd1,
        S_INTERROGATE = 2'd2,
        S_DETECT      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        counter_reset_q, counter_reset_d;
    logic        cycle_done_q, cycle_done_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic        err_overrun_q, err_overrun_d;
    logic        phase_load_q, phase_interrogate_q, phase_detect_q, busy_q;
    logic        in_range;

    // Is the counter inside the window the current phase expects?
    always_comb begin
        in_range = 1'b1;
        case (state_q)
            S_LOAD:        in_range = (count_in <= LOAD_END);
            S_INTERROGATE: in_range = (count_in >= INT_START) && (count_in <= INT_END);
            S_DETECT:      in_range = (count_in >= DET_START) && (count_in <= TOT_M1);
            default:       in_range = 1'b1;
        endcase
    end

    // Next-state and registered-output decode: abort beats overrun beats normal sequencing.
    always_comb begin
        state_d         = state_q;
        counter_reset_d = counter_reset_q;
        cycle_done_d    = 1'b0;
        cycle_count_d   = cycle_count_q;
        err_overrun_d   = err_overrun_q;
        if (abort && state_q != S_IDLE) begin
            state_d         = S_IDLE;
            counter_reset_d = 1'b1;
        end else if (state_q != S_IDLE && !in_range) begin
            state_d         = S_IDLE;
            counter_reset_d = 1'b1;
            err_overrun_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    counter_reset_d = 1'b1;
                    if (enable && !abort && !err_overrun_q) begin
                        state_d         = S_LOAD;
                        counter_reset_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (count_in == LOAD_END) state_d = S_INTERROGATE;
                end
                S_INTERROGATE: begin
                    if (count_in == INT_END) state_d = S_DETECT;
                end
                S_DETECT: begin
                    if (count_in == TOT_M1) begin
                        cycle_done_d  = 1'b1;
                        cycle_count_d = cycle_count_q + 16'd1;
                        if (enable) begin
                            state_d         = S_LOAD;
                            counter_reset_d = 1'b0;
                        end else begin
                            state_d         = S_IDLE;
                            counter_reset_d = 1'b1;
                        end
                    end else if (count_in == TOT_M2) begin
                        // Counter reset is seen during the last count so it wraps to 0 with the cycle.
                        counter_reset_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; phase flags are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            counter_reset_q     <= 1'b1;
            cycle_done_q        <= 1'b0;
            cycle_count_q       <= 16'd0;
            err_overrun_q       <= 1'b0;
            phase_load_q        <= 1'b0;
            phase_interrogate_q <= 1'b0;
            phase_detect_q      <= 1'b0;
            busy_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            counter_reset_q     <= counter_reset_d;
            cycle_done_q        <= cycle_done_d;
            cycle_count_q       <= cycle_count_d;
            err_overrun_q       <= err_overrun_d;
            phase_load_q        <= (state_d == S_LOAD);
            phase_interrogate_q <= (state_d == S_INTERROGATE);
            phase_detect_q      <= (state_d == S_DETECT);
            busy_q              <= (state_d != S_IDLE);
        end
    end

    assign counter_reset     = counter_reset_q;
    assign phase_load        = phase_load_q;
    assign phase_interrogate = phase_interrogate_q;
    assign phase_detect      = phase_detect_q;
    assign cycle_done        = cycle_done_q;
    assign cycle_count       = cycle_count_q;
    assign busy              = busy_q;
    assign err_overrun       = err_overrun_q;

endmodule

// File: tb/tb_clock_cycle_sequencer.sv
// tb/tb_clock_cycle_sequencer.sv - directed bench for clock_cycle_sequencer with a paired counter model
module tb_clock_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, abort;
    logic [7:0]  count_in;
    logic        counter_reset, phase_load, phase_interrogate, phase_detect;
    logic        cycle_done, busy, err_overrun;
    logic [15:0] cycle_count;

    logic [7:0]  cnt_q = 8'd0;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'd0;

    int errors = 0;
    int checks = 0;

    clock_cycle_sequencer #(
        .Nbits(8), .nclks_total(20), .nclks_load(8), .nclks_interrogate(5)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .abort(abort), .count_in(count_in),
        .counter_reset(counter_reset), .phase_load(phase_load),
        .phase_interrogate(phase_interrogate), .phase_detect(phase_detect),
        .cycle_done(cycle_done), .cycle_count(cycle_count), .busy(busy),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Paired free-running counter with synchronous reset
    always @(posedge clk) cnt_q <= counter_reset ? 8'd0 : cnt_q + 8'd1;
    assign count_in = force_en ? force_val : cnt_q;

    // {counter_reset, load, interrogate, detect, done, busy, err}
    wire [6:0] flags = {counter_reset, phase_load, phase_interrogate, phase_detect,
                        cycle_done, busy, err_overrun};

    typedef struct {
        logic       en;
        logic       ab;
        int         n;
        int         cnt0;
        int         step;
        logic [6:0] fl;
        logic [15:0] cc;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; abort = 1'b0; force_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_count(input logic [7:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (count_in == target) break;
            tick();
        end
        check("wait_count", {24'd0, count_in}, {24'd0, target});
    endtask

    task automatic wait_done(input int budget, output int took);
        took = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (cycle_done) begin
                took = i;
                break;
            end
        end
        check("wait_done_seen", {31'd0, cycle_done}, 32'd1);
    endtask

    initial begin
        int took, pulses, last, idle_seen;

        tbl[0] = '{1'b1, 1'b0, 1, 0,  1, 7'b0100010, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 7, 1,  1, 7'b0100010, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 5, 8,  1, 7'b0010010, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 6, 13, 1, 7'b0001010, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 1, 19, 1, 7'b1001010, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 1, 0,  0, 7'b1000100, 16'd1};
        tbl[6] = '{1'b0, 1'b0, 3, 0,  0, 7'b1000000, 16'd1};
        tbl[7] = '{1'b1, 1'b1, 2, 0,  0, 7'b1000000, 16'd1};

        do_reset();
        check("reset_state", {1'b0, flags, count_in, cycle_count}, {1'b0, 7'b1000000, 8'd0, 16'd0});

        // Single cycle then idle, including enable blocked by abort in IDLE
        for (int r = 0; r < 8; r++) begin
            enable = tbl[r].en;
            abort  = tbl[r].ab;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick();
                check($sformatf("vec%0d_%0d", r, k),
                      {1'b0, flags, count_in, cycle_count},
                      {1'b0, tbl[r].fl, 8'(tbl[r].cnt0 + k * tbl[r].step), tbl[r].cc});
            end
        end
        abort = 1'b0;

        // Back-to-back cycles
        do_reset();
        enable = 1'b1;
        pulses = 0; last = 0; idle_seen = 0;
        for (int t = 1; t <= 100 && pulses < 3; t++) begin
            tick();
            if (!busy) idle_seen++;
            if (cycle_done) begin
                pulses++;
                if (pulses > 1) check("b2b_spacing", t - last, 20);
                last = t;
                check("b2b_restart", {29'd0, phase_load, busy, counter_reset}, 32'b110);
                check("b2b_count0", {24'd0, count_in}, 32'd0);
            end
        end
        check("b2b_pulses", pulses, 3);
        check("b2b_cycle_count", {16'd0, cycle_count}, 32'd3);
        check("b2b_no_idle", idle_seen, 0);
        enable = 1'b0;
        wait_done(25, took);
        tick();
        check("b2b_stop_idle", {30'd0, busy, counter_reset}, 32'b01);

        // Enable dropped mid-cycle: cycle still completes
        do_reset();
        enable = 1'b1;
        wait_count(8'd10, 40);
        enable = 1'b0;
        wait_done(30, took);
        check("drop_latency", took, 10);
        check("drop_end", {1'b0, flags, count_in, cycle_count}, {1'b0, 7'b1000100, 8'd0, 16'd1});

        // Abort in DETECT, then abort on the terminal DETECT edge
        do_reset();
        enable = 1'b1;
        wait_done(30, took);
        wait_count(8'd15, 30);
        abort = 1'b1;
        tick();
        check("abort_detect", {1'b0, flags, cycle_count}, {1'b0, 7'b1000000, 16'd1});
        abort = 1'b0;
        tick();
        check("abort_restart", {23'd0, phase_load, count_in}, {23'd0, 1'b1, 8'd0});
        wait_count(8'd19, 30);
        abort = 1'b1;
        tick();
        check("abort_terminal", {1'b0, flags, cycle_count}, {1'b0, 7'b1000000, 16'd1});
        abort = 1'b0;
        enable = 1'b0;

        // Overrun: counter out of range in INTERROGATE
        do_reset();
        enable = 1'b1;
        wait_count(8'd10, 30);
        force_en = 1'b1; force_val = 8'd25;
        tick();
        force_en = 1'b0;
        check("ovr_int", {25'd0, flags}, {25'd0, 7'b1000001});
        tick(); tick(); tick();
        check("ovr_blocks_enable", {25'd0, flags}, {25'd0, 7'b1000001});
        do_reset();
        check("ovr_cleared", {31'd0, err_overrun}, 32'd0);
        enable = 1'b1;
        tick();
        check("ovr_rerun", {25'd0, flags}, {25'd0, 7'b0100010});
        // Overrun: in-range count that belongs to the wrong phase
        wait_count(8'd6, 30);
        force_en = 1'b1; force_val = 8'd8;
        tick();
        force_en = 1'b0;
        check("ovr_load", {25'd0, flags}, {25'd0, 7'b1000001});

        // cycle_count wrap
        do_reset();
        force dut.cycle_count_q = 16'hFFFF;
        tick();
        release dut.cycle_count_q;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_done(30, took);
        check("wrap_count", {16'd0, cycle_count}, 32'd0);
        check("wrap_done", {31'd0, cycle_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
